alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV32M MUL/DIV/DIVU/REM/REMU. It borrows the shared 32-bit integer ALU.
//  While busy it asserts aluReq, drives the ALU operands/aluOp, and consumes aluResult.
//  One add or sub per cycle: shift-add multiply, restoring divide.
//  Sits beside EX; the EX operand mux selects the sequencer's ALU inputs while aluReq=1.
// PARAMETERS
//  WIDTH  32  operand/result width
//  CNT_W  5   iteration counter width, $clog2(WIDTH)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request; accepted only when busy=0
//  func3       in   3      RV32M funct3: 0 MUL, 4 DIV, 5 DIVU, 6 REM, 7 REMU; 1-3 unsupported
//  opA         in   WIDTH  rs1 value (multiplicand/dividend), sampled at accept
//  opB         in   WIDTH  rs2 value (multiplier/divisor), sampled at accept
//  kill        in   1      synchronous abort (pipeline flush)
//  busy        out  1      operation in flight (state != IDLE)
//  done        out  1      one-cycle pulse; result valid
//  illegal     out  1      pulses with done for func3 1-3
//  result      out  WIDTH  held from done until next accept
//  aluReq      out  1      sequencer owns ALU this cycle
//  aluDataA    out  WIDTH  ALU operand A
//  aluDataB    out  WIDTH  ALU operand B
//  aluOp       out  3      000 add, 001 sub
//  aluFunc     out  4      tied 4'b0000
//  aluResult   in   WIDTH  combinational ALU output, same cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers = 0.
//  States: IDLE, NEGA, NEGB, LOOP, FIXUP, DONE. Accept cycle = cycle 0.
//  IDLE: if start, latch operands and func3, counter=0. Next state:
//   func3 1-3: DONE, illegal=1, result=0.
//   divisor==0: DONE. result=all-ones for DIV/DIVU; opA for REM/REMU.
//   DIV/REM with opA=0x80000000 and opB=0xFFFFFFFF: DONE. result=0x80000000 for DIV; 0 for REM.
//   signed op with opA<0: NEGA. Else signed op with opB<0: NEGB. Otherwise: LOOP.
//  NEGA: ALU computes 0-A (sub); A<=aluResult. Go to NEGB if B<0, else LOOP.
//  NEGB: ALU computes 0-B; B<=aluResult. Go to LOOP.
//  LOOP: exactly WIDTH cycles; counter increments and wraps 31->0 on exit.
//   MUL: if B[0], acc<=acc+A (ALU add); A<=A<<1; B<=B>>1. Low 32 bits only, so signedness is irrelevant.
//   DIV step: r33={rem,quo[31]}. Drive ALU sub with r33[31:0], divisor.
//    ge = r33[32] | (r33[31:0] >= divisor), local unsigned compare.
//    If ge: rem<=aluResult (mod 2^32 is exact). Else rem<=r33[31:0].
//    quo<={quo[30:0],ge}.
//  After LOOP: FIXUP if a negation is needed, else DONE.
//   DIV negates the quotient when the operand signs differ.
//   REM negates the remainder when the dividend is negative.
//  FIXUP: ALU computes 0-x; go to DONE.
//  DONE: done=1; result registered; next state IDLE. busy stays high through DONE.
//  Latency, accept cycle to done:
//   special cases: 1 cycle
//   unsigned ops and MUL: 33 cycles
//   signed DIV/REM: 33 + NEGA + NEGB + FIXUP, max 36 cycles
//  Next start can be accepted the cycle after done. start while busy is ignored, not queued.
//  kill (any non-IDLE state): next state IDLE. No done. result unchanged. aluReq low next cycle.
//   kill in the same cycle as start from IDLE: start wins.
//  aluReq=1 only in NEGA, NEGB, LOOP, FIXUP.
//   When aluReq=0: aluDataA/aluDataB=0 and aluOp=000.
//  rst_n low mid-operation: immediate return to reset values; no done.
// STRUCTURE
//  Shared package alu_pkg holds:
//   ALUOP_ADD=3'b000, ALUOP_SUB=3'b001
//   F3_MUL/F3_DIV/F3_DIVU/F3_REM/F3_REMU
//   state encoding localparams
//  No sub-module. One FSM + counter + operand/acc registers.
//  The ALU stays a separate instance, shared through the EX mux.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at cycle 33, aluOp=000 during LOOP.
//  DIV -7/2 -> 0xFFFFFFFD at cycle 35. REM -7%2 -> 0xFFFFFFFF at cycle 35.
//  DIVU 100/0 -> 0xFFFFFFFF at cycle 1. REMU 100%0 -> 100.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
//  func3=2 -> done=illegal=1 at cycle 1, result 0. start held high while busy -> exactly one done.
//  kill at cycle 10 of DIVU -> busy=0 and aluReq=0 next cycle, no done, prior result retained.
//  rst_n low at cycle 20 -> all outputs 0 immediately. Back-to-back DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants for the integer ALU and the RV32M multi-cycle
//             sequencer: ALU opcodes, RV32M funct3 codes, sequencer state
//             encoding and small funct3 decode helpers.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU operation select
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;

    // RV32M funct3 codes handled by the sequencer
    localparam logic [2:0] F3_MUL  = 3'd0;
    localparam logic [2:0] F3_DIV  = 3'd4;
    localparam logic [2:0] F3_DIVU = 3'd5;
    localparam logic [2:0] F3_REM  = 3'd6;
    localparam logic [2:0] F3_REMU = 3'd7;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NEGA  = 3'd1;
    localparam logic [2:0] ST_NEGB  = 3'd2;
    localparam logic [2:0] ST_LOOP  = 3'd3;
    localparam logic [2:0] ST_FIXUP = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_NEGA  = ST_NEGA,
        S_NEGB  = ST_NEGB,
        S_LOOP  = ST_LOOP,
        S_FIXUP = ST_FIXUP,
        S_DONE  = ST_DONE
    } seq_state_e;

    // funct3 values 1-3 are not part of the supported subset
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 == F3_MUL) || f3[2];
    endfunction

    // DIV and REM work on signed operands
    function automatic logic f3_is_signed_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_seq
//  Purpose  : Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer that borrows
//             the shared integer ALU (one add or sub per cycle). Shift-add
//             multiply, restoring divide, sign handling by explicit negation.
//  Ports    : clk, rst_n (async, active-low)
//             start/func3/opA/opB  request, sampled when idle
//             kill                 synchronous abort
//             busy/done/illegal/result  status and result
//             aluReq/aluDataA/aluDataB/aluOp/aluFunc  ALU borrow interface
//             aluResult            combinational ALU output
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    output logic             aluReq,
    output logic [WIDTH-1:0] aluDataA,
    output logic [WIDTH-1:0] aluDataB,
    output logic [2:0]       aluOp,
    output logic [3:0]       aluFunc,
    input  logic [WIDTH-1:0] aluResult
);
    import alu_pkg::*;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [2:0]       func3_q, func3_d;
    // a: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
    logic [WIDTH-1:0] a_q, a_d;
    // b: multiplier (MUL) or divisor (DIV/REM)
    logic [WIDTH-1:0] b_q, b_d;
    // acc: product accumulator (MUL) or partial remainder (DIV/REM)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_res_q, neg_res_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   r33;
    logic             ge;
    logic             sdiv_in;

    always_comb begin
        state_d   = state_q;
        func3_d   = func3_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        aluReq    = 1'b0;
        aluDataA  = '0;
        aluDataB  = '0;
        aluOp     = ALUOP_ADD;
        sdiv_in   = f3_is_signed_div(func3);
        // Restoring-divide trial: partial remainder shifted left by one
        // with the next dividend bit brought in.
        r33       = {acc_q, a_q[WIDTH-1]};
        ge        = r33[WIDTH] | (r33[WIDTH-1:0] >= b_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    func3_d   = func3;
                    a_d       = opA;
                    b_d       = opB;
                    acc_d     = '0;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                    neg_res_d = 1'b0;
                    if (!f3_is_legal(func3)) begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                        result_d  = '0;
                    end else if (func3[2] && (opB == '0)) begin
                        state_d  = S_DONE;
                        result_d = func3[1] ? opA : '1;
                    end else if (sdiv_in && (opA == MIN_NEG) && (opB == '1)) begin
                        state_d  = S_DONE;
                        result_d = func3[1] ? '0 : MIN_NEG;
                    end else begin
                        // REM follows the dividend sign, DIV the sign product
                        neg_res_d = sdiv_in &
                                    (func3[1] ? opA[WIDTH-1]
                                              : (opA[WIDTH-1] ^ opB[WIDTH-1]));
                        if (sdiv_in && opA[WIDTH-1])
                            state_d = S_NEGA;
                        else if (sdiv_in && opB[WIDTH-1])
                            state_d = S_NEGB;
                        else
                            state_d = S_LOOP;
                    end
                end
            end
            S_NEGA: begin
                aluReq   = 1'b1;
                aluOp    = ALUOP_SUB;
                aluDataB = a_q;
                a_d      = aluResult;
                state_d  = b_q[WIDTH-1] ? S_NEGB : S_LOOP;
            end
            S_NEGB: begin
                aluReq   = 1'b1;
                aluOp    = ALUOP_SUB;
                aluDataB = b_q;
                b_d      = aluResult;
                state_d  = S_LOOP;
            end
            S_LOOP: begin
                aluReq = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (func3_q == F3_MUL) begin
                    aluOp    = ALUOP_ADD;
                    aluDataA = acc_q;
                    aluDataB = a_q;
                    if (b_q[0])
                        acc_d = aluResult;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else begin
                    aluOp    = ALUOP_SUB;
                    aluDataA = r33[WIDTH-1:0];
                    aluDataB = b_q;
                    // Subtraction wraps mod 2^WIDTH, exact whenever ge holds
                    acc_d    = ge ? aluResult : r33[WIDTH-1:0];
                    a_d      = {a_q[WIDTH-2:0], ge};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (neg_res_q) begin
                        state_d = S_FIXUP;
                    end else begin
                        state_d  = S_DONE;
                        result_d = ((func3_q == F3_DIV) || (func3_q == F3_DIVU))
                                   ? a_d : acc_d;
                    end
                end
            end
            S_FIXUP: begin
                aluReq   = 1'b1;
                aluOp    = ALUOP_SUB;
                aluDataB = func3_q[1] ? acc_q : a_q;
                result_d = aluResult;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort from any active state; the previous result is preserved
        if (kill && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            func3_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            func3_q   <= func3_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign illegal = done & illegal_q;
    assign result  = result_q;
    assign aluFunc = 4'b0000;

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv_seq
//  Purpose  : Self-checking bench for alu_muldiv_seq with an arithmetic
//             reference model and a behavioural shared ALU.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        kill;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [31:0] result;
    logic        aluReq;
    logic [31:0] aluDataA;
    logic [31:0] aluDataB;
    logic [2:0]  aluOp;
    logic [3:0]  aluFunc;
    logic [31:0] aluResult;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Shared integer ALU: add or sub, combinational
    assign aluResult = (aluOp == 3'b001) ? (aluDataA - aluDataB) : (aluDataA + aluDataB);

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .func3     (func3),
        .opA       (opA),
        .opB       (opB),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .result    (result),
        .aluReq    (aluReq),
        .aluDataA  (aluDataA),
        .aluDataB  (aluDataB),
        .aluOp     (aluOp),
        .aluFunc   (aluFunc),
        .aluResult (aluResult)
    );

    // Reference: RV32M semantics with plain arithmetic, latency from op rules
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa  = a;
        sb  = b;
        ill = 1'b0;
        lat = 33;
        r   = 32'd0;
        case (f3)
            3'd0: r = a * b;
            3'd5: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end else r = a / b;
            3'd7: if (b == 0) begin r = a; lat = 1; end else r = a % b;
            3'd4: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
                else begin
                    r   = 32'(sa / sb);
                    lat = 33 + (sa < 0 ? 1 : 0) + (sb < 0 ? 1 : 0) + (((sa < 0) != (sb < 0)) ? 1 : 0);
                end
            end
            3'd6: begin
                if (b == 0) begin r = a; lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
                else begin
                    r   = 32'(sa % sb);
                    lat = 33 + (sa < 0 ? 2 : 0) + (sb < 0 ? 1 : 0);
                end
            end
            default: begin ill = 1'b1; r = 32'd0; lat = 1; end
        endcase
    endfunction

    // Issue one operation at the next idle cycle and observe until done
    task automatic exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat,
                        output logic op_bad, output logic bus_bad);
        lat = 0; res = 32'd0; ill = 1'b0; op_bad = 1'b0; bus_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; func3 = f3; opA = a; opB = b;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; opA = $urandom; opB = $urandom; func3 = 3'($urandom);
            end
            if (!aluReq && (aluDataA != 0 || aluDataB != 0 || aluOp != 3'b000)) bus_bad = 1'b1;
            if (aluFunc != 4'b0000 || !busy) bus_bad = 1'b1;
            if (aluReq && f3 == 3'd0 && aluOp != 3'b000) op_bad = 1'b1;
            if (done) begin
                lat = c; res = result; ill = illegal;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, illegal, result, aluReq, aluDataA, aluDataB, aluOp, aluFunc} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b ill=%b res=%h req=%b A=%h B=%h op=%b fn=%b required all zero",
                     busy, done, illegal, result, aluReq, aluDataA, aluDataB, aluOp, aluFunc);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_f3  [11] = '{3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd2, 3'd4, 3'd6, 3'd4};
        logic [31:0] t_a   [11] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                    32'h8000_0000, 32'h8000_0000, 32'd5, 32'd100, 32'hFFFF_FF9C, 32'd5};
        logic [31:0] t_b   [11] = '{32'hFFFF_FFFD, 32'd2, 32'd2, 32'd0, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0};
        logic [31:0] t_r   [11] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                                    32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int          t_lat [11] = '{33, 35, 35, 1, 1, 1, 1, 1, 35, 36, 1};
        logic [31:0] res;
        logic        ill, op_bad, bus_bad;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            exec(t_f3[i], t_a[i], t_b[i], res, ill, lat, op_bad, bus_bad);
            n_checks++;
            if (res !== t_r[i]) $display("FAIL dir%0d_result: got %h required %h", i, res, t_r[i]);
            else n_pass++;
            n_checks++;
            if (lat !== t_lat[i]) $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, t_lat[i]);
            else n_pass++;
            n_checks++;
            if (ill !== (t_f3[i] == 3'd2)) $display("FAIL dir%0d_illegal: got %b required %b", i, ill, t_f3[i] == 3'd2);
            else n_pass++;
            n_checks++;
            if ({op_bad, bus_bad} !== 2'b00) $display("FAIL dir%0d_alu_bus: got op_bad=%b bus_bad=%b required 0 0", i, op_bad, bus_bad);
            else n_pass++;
        end
    endtask

    task automatic test_start_held();
        int          dones = 0;
        logic [31:0] res = 32'd0;
        @(negedge clk);
        start = 1'b1; func3 = 3'd5; opA = 32'd1000; opB = 32'd3;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin
                dones++; res = result; start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 1) $display("FAIL start_held_dones: got %0d required 1", dones);
        else n_pass++;
        n_checks++;
        if (res !== 32'd333) $display("FAIL start_held_result: got %h required %h", res, 32'd333);
        else n_pass++;
    endtask

    task automatic test_kill();
        logic [31:0] res;
        logic        ill, op_bad, bus_bad;
        int          lat;
        int          dones = 0;
        exec(3'd5, 32'd100, 32'd7, res, ill, lat, op_bad, bus_bad);
        n_checks++;
        if (res !== 32'd14) $display("FAIL kill_prior_result: got %h required %h", res, 32'd14);
        else n_pass++;
        @(negedge clk);
        start = 1'b1; func3 = 3'd5; opA = 32'hDEAD_BEEF; opB = 32'd3;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_checks++;
        if ({busy, aluReq} !== 2'b00) $display("FAIL kill_idle: got busy=%b aluReq=%b required 0 0", busy, aluReq);
        else n_pass++;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL kill_no_done: got %0d dones required 0", dones);
        else n_pass++;
        n_checks++;
        if (result !== 32'd14) $display("FAIL kill_result_kept: got %h required %h", result, 32'd14);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        ill, op_bad, bus_bad;
        int          lat;
        exec(3'd5, 32'hFFFF_FFFF, 32'd1, res, ill, lat, op_bad, bus_bad);
        n_checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 33) $display("FAIL b2b_first: got %h lat %0d required ffffffff lat 33", res, lat);
        else n_pass++;
        exec(3'd5, 32'hFFFF_FFFF, 32'h10, res, ill, lat, op_bad, bus_bad);
        n_checks++;
        if (res !== 32'h0FFF_FFFF || lat !== 33 || bus_bad !== 1'b0)
            $display("FAIL b2b_second: got %h lat %0d bus_bad %b required 0fffffff lat 33 bus_bad 0", res, lat, bus_bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp_r;
        logic        ill, exp_ill, op_bad, bus_bad;
        int          lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            f3 = f3s[$urandom_range(0, 5)];
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                3: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(f3, a, b, exp_r, exp_ill, exp_lat);
            exec(f3, a, b, res, ill, lat, op_bad, bus_bad);
            n_checks++;
            if (res !== exp_r || ill !== exp_ill || lat !== exp_lat || op_bad || bus_bad)
                $display("FAIL rand%0d f3=%0d a=%h b=%h: got res=%h ill=%b lat=%0d opbad=%b busbad=%b required res=%h ill=%b lat=%0d",
                         i, f3, a, b, res, ill, lat, op_bad, bus_bad, exp_r, exp_ill, exp_lat);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; func3 = 3'd0; opA = 32'd12345; opB = 32'd678;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, illegal, result, aluReq, aluDataA, aluDataB, aluOp, aluFunc} !== '0)
            $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h req=%b A=%h B=%h op=%b required all zero",
                     busy, done, result, aluReq, aluDataA, aluDataB, aluOp);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0 || busy !== 1'b0) $display("FAIL reset_mid_no_done: got dones=%0d busy=%b required 0 0", dones, busy);
        else n_pass++;
    endtask

    initial begin
        start = 1'b0; kill = 1'b0; func3 = 3'd0; opA = 32'd0; opB = 32'd0;
        test_reset();
        test_directed();
        test_start_held();
        test_kill();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
